board_capture: RTL and testbench

BOARD_CAPTURE -- requirements
Module: board_capture

---
 rtl/fpgachess_pkg.sv | 24 ++
 rtl/board_capture.sv | 117 +++++++++++
 tb/tb_board_capture.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fpgachess_pkg.sv
// fpgachess_pkg: square codes, piece constants, square index type and error bit indices.
package fpgachess_pkg;
  typedef logic [5:0] sq_t;
  typedef logic [2:0] piece_t;
  localparam piece_t PC_NONE = 3'd0;
  localparam piece_t PC_K    = 3'd1;
  localparam piece_t PC_Q    = 3'd2;
  localparam piece_t PC_R    = 3'd3;
  localparam piece_t PC_B    = 3'd4;
  localparam piece_t PC_N    = 3'd5;
  localparam piece_t PC_P    = 3'd6;
  localparam piece_t PC_BAD  = 3'd7;
  typedef struct packed {
    logic   white;
    piece_t piece;
  } sqcode_t;
  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_CODE  = 2;
  localparam int ERR_WKING = 3;
  localparam int ERR_BKING = 4;
  localparam int ERR_PAWN  = 5;
  typedef enum logic {IDLE, LOAD} state_t;
endpackage

// File: rtl/board_capture.sv
// board_capture: assembles a 64-square stream into a validated board snapshot with handshake.
module board_capture
  import fpgachess_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_pos_valid,
  input  logic         in_pos_sop,
  input  logic         in_pos_eop,
  input  logic [3:0]   in_pos_data,
  input  logic         in_wtp,
  input  logic [3:0]   in_castle,
  input  logic [2:0]   in_ep,
  input  logic [15:0]  in_hmcount,
  input  logic [15:0]  in_fmcount,
  output logic [255:0] o_board,
  output logic         o_wtp,
  output logic [3:0]   o_castle,
  output logic [2:0]   o_ep,
  output logic [15:0]  o_hmcount,
  output logic [15:0]  o_fmcount,
  output logic [5:0]   o_wking_sq,
  output logic [5:0]   o_bking_sq,
  output logic [5:0]   o_err,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_overrun
);
  state_t           state_q;
  logic [63:0][3:0] wb_q, wb_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [1:0]       wkc_q, wkc_d, bkc_q, bkc_d;
  sq_t              wks_q, wks_d, bks_q, bks_d;
  logic [5:0]       werr_q, werr_d, fin_err;
  sqcode_t          code;
  logic             beat, done, accept;
  // The _d values already include the current beat, so a sop+eop beat completes with itself.
  always_comb begin
    code   = sqcode_t'(in_pos_data);
    beat   = in_pos_valid && (in_pos_sop || state_q == LOAD);
    done   = beat && in_pos_eop;
    accept = done && (!o_valid || i_ready);
    wb_d   = in_pos_sop ? '0 : wb_q;
    cnt_d  = in_pos_sop ? '0 : cnt_q;
    wkc_d  = in_pos_sop ? '0 : wkc_q;
    bkc_d  = in_pos_sop ? '0 : bkc_q;
    wks_d  = in_pos_sop ? '0 : wks_q;
    bks_d  = in_pos_sop ? '0 : bks_q;
    werr_d = in_pos_sop ? '0 : werr_q;
    if (beat && cnt_d[6]) werr_d[ERR_LONG] = 1'b1;
    else if (beat) begin
      wb_d[cnt_d[5:0]] = in_pos_data;
      if (code.piece == PC_BAD) werr_d[ERR_CODE] = 1'b1;
      if (code.piece == PC_K && code.white) begin
        wkc_d = (wkc_d == 2'd3) ? 2'd3 : wkc_d + 2'd1;
        wks_d = cnt_d[5:0];
      end
      if (code.piece == PC_K && !code.white) begin
        bkc_d = (bkc_d == 2'd3) ? 2'd3 : bkc_d + 2'd1;
        bks_d = cnt_d[5:0];
      end
      if (code.piece == PC_P && (cnt_d[5:3] == 3'd0 || cnt_d[5:3] == 3'd7)) werr_d[ERR_PAWN] = 1'b1;
      cnt_d = cnt_d + 7'd1;
    end
    fin_err            = werr_d;
    fin_err[ERR_SHORT] = !cnt_d[6];
    fin_err[ERR_WKING] = wkc_d != 2'd1;
    fin_err[ERR_BKING] = bkc_d != 2'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_q       <= '0;
      cnt_q      <= '0;
      wkc_q      <= '0;
      bkc_q      <= '0;
      wks_q      <= '0;
      bks_q      <= '0;
      werr_q     <= '0;
      o_board    <= '0;
      o_wtp      <= 1'b0;
      o_castle   <= '0;
      o_ep       <= '0;
      o_hmcount  <= '0;
      o_fmcount  <= '0;
      o_wking_sq <= '0;
      o_bking_sq <= '0;
      o_err      <= '0;
      o_valid    <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      if (beat) begin
        state_q <= done ? IDLE : LOAD;
        wb_q    <= wb_d;
        cnt_q   <= cnt_d;
        wkc_q   <= wkc_d;
        bkc_q   <= bkc_d;
        wks_q   <= wks_d;
        bks_q   <= bks_d;
        werr_q  <= werr_d;
      end
      if (accept) begin
        o_board    <= wb_d;
        o_wtp      <= in_wtp;
        o_castle   <= in_castle;
        o_ep       <= in_ep;
        o_hmcount  <= in_hmcount;
        o_fmcount  <= in_fmcount;
        o_wking_sq <= wks_d;
        o_bking_sq <= bks_d;
        o_err      <= fin_err;
        o_valid    <= 1'b1;
      end else if (o_valid && i_ready) o_valid <= 1'b0;
      if (done && !accept) o_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_board_capture.sv
// tb_board_capture: random-stimulus bench comparing snapshots against a list-based board model.
module tb_board_capture;
  logic         clk = 1'b0;
  logic         rst, in_pos_valid, in_pos_sop, in_pos_eop, in_wtp, i_ready;
  logic [3:0]   in_pos_data, in_castle;
  logic [2:0]   in_ep;
  logic [15:0]  in_hmcount, in_fmcount;
  logic [255:0] o_board;
  logic         o_wtp, o_valid, o_overrun;
  logic [3:0]   o_castle;
  logic [2:0]   o_ep;
  logic [15:0]  o_hmcount, o_fmcount;
  logic [5:0]   o_wking_sq, o_bking_sq, o_err;

  board_capture dut (
    .clk(clk), .rst(rst), .in_pos_valid(in_pos_valid), .in_pos_sop(in_pos_sop),
    .in_pos_eop(in_pos_eop), .in_pos_data(in_pos_data), .in_wtp(in_wtp),
    .in_castle(in_castle), .in_ep(in_ep), .in_hmcount(in_hmcount), .in_fmcount(in_fmcount),
    .o_board(o_board), .o_wtp(o_wtp), .o_castle(o_castle), .o_ep(o_ep),
    .o_hmcount(o_hmcount), .o_fmcount(o_fmcount), .o_wking_sq(o_wking_sq),
    .o_bking_sq(o_bking_sq), .o_err(o_err), .o_valid(o_valid), .i_ready(i_ready),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int               errors = 0, checks = 0;
  logic [3:0]       stim[$];
  logic [63:0][3:0] exp_board;
  logic [5:0]       exp_wk, exp_bk, exp_err;
  logic [39:0]      exp_side;
  logic             valid_at_eop;
  logic [315:0]     snap, want;
  assign snap = {o_valid, o_overrun, o_board, o_wking_sq, o_bking_sq, o_err,
                 o_wtp, o_castle, o_ep, o_hmcount, o_fmcount};

  // Reference: walk the square list, apply the rules directly with integer counters.
  task automatic model();
    int wn = 0, bn = 0;
    exp_board = '0; exp_wk = '0; exp_bk = '0; exp_err = '0;
    for (int i = 0; i < stim.size(); i++) begin
      if (i >= 64) begin exp_err[1] = 1'b1; continue; end
      exp_board[i] = stim[i];
      if (stim[i][2:0] == 3'd7) exp_err[2] = 1'b1;
      if (stim[i] == 4'h9) begin wn++; exp_wk = 6'(i); end
      if (stim[i] == 4'h1) begin bn++; exp_bk = 6'(i); end
      if (stim[i][2:0] == 3'd6 && (i < 8 || i >= 56)) exp_err[5] = 1'b1;
    end
    exp_err[0] = stim.size() < 64;
    exp_err[3] = wn != 1;
    exp_err[4] = bn != 1;
  endtask

  task automatic set_side();
    in_wtp = 1'($urandom); in_castle = 4'($urandom); in_ep = 3'($urandom);
    in_hmcount = 16'($urandom); in_fmcount = 16'($urandom);
    exp_side = {in_wtp, in_castle, in_ep, in_hmcount, in_fmcount};
  endtask

  task automatic start_pos();
    logic [3:0] back [8] = '{4'h3, 4'h5, 4'h4, 4'h2, 4'h1, 4'h4, 4'h5, 4'h3};
    stim = {};
    for (int i = 0; i < 8; i++) stim.push_back(back[i]);
    for (int i = 0; i < 8; i++) stim.push_back(4'h6);
    for (int i = 0; i < 32; i++) stim.push_back(4'h0);
    for (int i = 0; i < 8; i++) stim.push_back(4'hE);
    for (int i = 0; i < 8; i++) stim.push_back(back[i] + 4'h8);
  endtask

  task automatic rand_stream(input int n);
    stim = {};
    for (int i = 0; i < n; i++) stim.push_back(4'($urandom_range(0, 15)));
  endtask

  task automatic send(input bit with_sop, input bit rdy_eop, input int max_gap);
    set_side();
    for (int i = 0; i < stim.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        in_pos_valid = 1'b0; in_pos_sop = 1'($urandom); in_pos_eop = 1'($urandom);
        in_pos_data = 4'($urandom);
      end
      @(negedge clk);
      in_pos_valid = 1'b1; in_pos_sop = with_sop && i == 0;
      in_pos_eop = i == stim.size() - 1; in_pos_data = stim[i];
      if (in_pos_eop) begin valid_at_eop = o_valid; if (rdy_eop) i_ready = 1'b1; end
    end
    @(negedge clk);
    in_pos_valid = 1'b0; in_pos_sop = 1'b0; in_pos_eop = 1'b0; i_ready = 1'b0;
  endtask

  task automatic partial(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_pos_valid = 1'b1; in_pos_sop = i == 0; in_pos_eop = 1'b0; in_pos_data = 4'($urandom);
    end
  endtask

  task automatic consume();
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_pos_valid = 1'b0; in_pos_sop = 1'b0; in_pos_eop = 1'b0; in_pos_data = '0;
    i_ready = 1'b0; set_side();
    repeat (3) @(negedge clk);
    checks++; if (snap !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", snap); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (snap !== '0) begin errors++; $display("FAIL reset_idle: got %h want 0", snap); end
  endtask

  task automatic test_start_pos();
    start_pos(); model(); send(1, 0, 1);
    checks++; if (valid_at_eop !== 1'b0) begin errors++; $display("FAIL start_pre_valid: got %b want 0", valid_at_eop); end
    want = {2'b10, exp_board, exp_wk, exp_bk, exp_err, exp_side};
    checks++; if (snap !== want) begin errors++; $display("FAIL start_snapshot: got %h want %h", snap, want); end
    checks++; if ({o_board[3:0], o_board[19:16], o_board[243:240], o_board[255:252]} !== 16'h319B) begin
      errors++; $display("FAIL start_squares: got %h want 319b", {o_board[3:0], o_board[19:16], o_board[243:240], o_board[255:252]}); end
    checks++; if ({o_bking_sq, o_wking_sq, o_err} !== {6'd4, 6'd60, 6'd0}) begin
      errors++; $display("FAIL start_kings_err: got %0d %0d %b want 4 60 000000", o_bking_sq, o_wking_sq, o_err); end
    consume();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL start_handshake: got %b want 0", o_valid); end
  endtask

  task automatic test_short();
    start_pos(); void'(stim.pop_back()); model(); send(1, 0, 2);
    want = {2'b10, exp_board, exp_wk, exp_bk, exp_err, exp_side};
    checks++; if (snap !== want) begin errors++; $display("FAIL short_snapshot: got %h want %h", snap, want); end
    checks++; if (o_err !== 6'b000001) begin errors++; $display("FAIL short_err: got %b want 000001", o_err); end
    consume();
  endtask

  task automatic test_long();
    start_pos(); stim.push_back(4'h6); model(); send(1, 0, 2);
    want = {2'b10, exp_board, exp_wk, exp_bk, exp_err, exp_side};
    checks++; if (snap !== want) begin errors++; $display("FAIL long_snapshot: got %h want %h", snap, want); end
    checks++; if ({o_err, o_board[255:252]} !== {6'b000010, 4'hB}) begin
      errors++; $display("FAIL long_err_sq63: got %b %h want 000010 b", o_err, o_board[255:252]); end
    consume();
  endtask

  task automatic test_kings();
    start_pos(); stim[62] = 4'h9; stim[3] = 4'h6; model(); send(1, 0, 1);
    want = {2'b10, exp_board, exp_wk, exp_bk, exp_err, exp_side};
    checks++; if (snap !== want) begin errors++; $display("FAIL kings_snapshot: got %h want %h", snap, want); end
    checks++; if ({o_err, o_wking_sq} !== {6'b101000, 6'd62}) begin
      errors++; $display("FAIL kings_err: got %b %0d want 101000 62", o_err, o_wking_sq); end
    consume();
  endtask

  task automatic test_back_to_back();
    start_pos(); send(1, 0, 0);
    partial(20);
    rand_stream(64); model(); send(1, 1, 1);
    checks++; if (valid_at_eop !== 1'b1) begin errors++; $display("FAIL b2b_valid_at_eop: got %b want 1", valid_at_eop); end
    want = {2'b10, exp_board, exp_wk, exp_bk, exp_err, exp_side};
    checks++; if (snap !== want) begin errors++; $display("FAIL b2b_snapshot: got %h want %h", snap, want); end
    consume();
    rand_stream(1); stim[0] = 4'h9; model(); send(1, 0, 0);
    want = {2'b10, exp_board, exp_wk, exp_bk, exp_err, exp_side};
    checks++; if (snap !== want) begin errors++; $display("FAIL single_beat: got %h want %h", snap, want); end
    consume();
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      rand_stream($urandom_range(60, 67)); model(); send(1, 0, 2);
      want = {2'b10, exp_board, exp_wk, exp_bk, exp_err, exp_side};
      checks++; if (snap !== want) begin errors++; $display("FAIL random_%0d: got %h want %h", k, snap, want); end
      consume();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL random_ack_%0d: got %b want 0", k, o_valid); end
    end
  endtask

  task automatic test_overrun();
    logic [313:0] first;
    rand_stream(64); model(); send(1, 0, 1);
    first = {exp_board, exp_wk, exp_bk, exp_err, exp_side};
    rand_stream(64); send(1, 0, 1);
    want = {2'b11, first};
    checks++; if (snap !== want) begin errors++; $display("FAIL overrun_hold: got %h want %h", snap, want); end
    consume();
    checks++; if ({o_valid, o_overrun} !== 2'b01) begin
      errors++; $display("FAIL overrun_release: got %b want 01", {o_valid, o_overrun}); end
  endtask

  task automatic test_reset_mid();
    partial(30);
    @(negedge clk);
    rst = 1'b1; in_pos_valid = 1'b1; in_pos_sop = 1'b0; in_pos_eop = 1'b1; in_pos_data = 4'h9;
    @(negedge clk);
    rst = 1'b0; in_pos_valid = 1'b0; in_pos_eop = 1'b0;
    checks++; if (snap !== '0) begin errors++; $display("FAIL midreset_clear: got %h want 0", snap); end
    rand_stream(64); send(0, 0, 1);
    checks++; if (snap !== '0) begin errors++; $display("FAIL nosop_ignored: got %h want 0", snap); end
    rand_stream(64); model(); send(1, 0, 1);
    want = {2'b10, exp_board, exp_wk, exp_bk, exp_err, exp_side};
    checks++; if (snap !== want) begin errors++; $display("FAIL midreset_next: got %h want %h", snap, want); end
    consume();
  endtask

  initial begin
    test_reset();
    test_start_pos();
    test_short();
    test_long();
    test_kings();
    test_back_to_back();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
